ram_rr_scheduler: RTL and testbench

//   Round-robin scheduler sharing one single-port synchronous RAM between NUM_CLIENTS requesters.

---
 rtl/ram_rr_scheduler_if.sv | 35 +++
 rtl/ram_rr_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_ram_rr_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_rr_scheduler_if.sv
// Bundle of client handshake and RAM-side signals for ram_rr_scheduler.
// master: client logic plus RAM macro (drives requests and read data).
// slave : the scheduler itself.
`timescale 1ns/1ps
interface ram_rr_scheduler_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8
);
    logic                          rst_done;
    logic [NUM_CLIENTS-1:0]        req;
    logic [NUM_CLIENTS-1:0]        rd_not_write;
    logic [NUM_CLIENTS*ADDR_W-1:0] addr;
    logic [NUM_CLIENTS*DATA_W-1:0] datain;
    logic [NUM_CLIENTS-1:0]        ack;
    logic [DATA_W-1:0]             dataout;
    logic [2:0]                    grant_id;
    logic                          mem_en;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [DATA_W-1:0]             mem_wdata;
    logic [DATA_W-1:0]             mem_rdata;

    modport master (
        output req, rd_not_write, addr, datain, mem_rdata,
        input  rst_done, ack, dataout, grant_id,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, rd_not_write, addr, datain, mem_rdata,
        output rst_done, ack, dataout, grant_id,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ram_rr_scheduler.sv
// Round-robin scheduler sharing one single-port synchronous RAM between
// NUM_CLIENTS requesters. Each access takes three cycles: grant in IDLE,
// RAM access in ISSUE, read-data capture and ACK in WAIT.
// Optional macro RAM_CLEAR_EN: sweep the RAM to zero after reset before
// accepting any request.
`timescale 1ns/1ps
module ram_rr_scheduler #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    ram_rr_scheduler_if.slave    bus
);
    localparam logic [2:0]        LAST_CLIENT = 3'(NUM_CLIENTS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

    typedef enum logic [1:0] {
`ifdef RAM_CLEAR_EN
        S_CLEAR = 2'd0,
`endif
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

`ifdef RAM_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t                 r_state,     w_state_next;
    logic                   r_rst_done,  w_rst_done_next;
    logic [NUM_CLIENTS-1:0] r_ack,       w_ack_next;
    logic [DATA_W-1:0]      r_dataout,   w_dataout_next;
    logic [2:0]             r_grant_id,  w_grant_id_next;
    logic [2:0]             r_ptr,       w_ptr_next;
    logic                   r_rd,        w_rd_next;
    logic                   r_mem_en,    w_mem_en_next;
    logic                   r_mem_we,    w_mem_we_next;
    logic [ADDR_W-1:0]      r_mem_addr,  w_mem_addr_next;
    logic [DATA_W-1:0]      r_mem_wdata, w_mem_wdata_next;

    // Client inputs padded to 8 slots so a 3-bit index is always in range.
    logic [7:0]        w_req_pad;
    logic [7:0]        w_rd_pad;
    logic [ADDR_W-1:0] w_addr_arr [8];
    logic [DATA_W-1:0] w_data_arr [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_client
            if (gi < NUM_CLIENTS) begin : g_live
                // A client being acked this cycle is masked so it cannot be re-granted.
                assign w_req_pad[gi]  = bus.req[gi] & ~r_ack[gi];
                assign w_rd_pad[gi]   = bus.rd_not_write[gi];
                assign w_addr_arr[gi] = bus.addr[gi*ADDR_W +: ADDR_W];
                assign w_data_arr[gi] = bus.datain[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign w_req_pad[gi]  = 1'b0;
                assign w_rd_pad[gi]   = 1'b0;
                assign w_addr_arr[gi] = '0;
                assign w_data_arr[gi] = '0;
            end
        end
    endgenerate

    logic       w_found;
    logic [2:0] w_pick;
    logic [3:0] w_cand;

    // Round-robin search: first eligible requester after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            w_cand = {1'b0, r_ptr} + 4'(k);
            if (w_cand >= 4'(NUM_CLIENTS)) begin
                w_cand = w_cand - 4'(NUM_CLIENTS);
            end
            if (!w_found && w_req_pad[w_cand[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[2:0];
            end
        end
    end

    // Next-state and next-output logic; RAM strobes default low every cycle.
    always_comb begin
        w_state_next     = r_state;
`ifdef RAM_CLEAR_EN
        w_rst_done_next  = r_rst_done;
`else
        w_rst_done_next  = 1'b1;
`endif
        w_ack_next       = '0;
        w_dataout_next   = r_dataout;
        w_grant_id_next  = r_grant_id;
        w_ptr_next       = r_ptr;
        w_rd_next        = r_rd;
        w_mem_en_next    = 1'b0;
        w_mem_we_next    = 1'b0;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        case (r_state)
`ifdef RAM_CLEAR_EN
            S_CLEAR: begin
                // r_mem_en doubles as "sweep started"; the address register is the counter.
                if (!r_mem_en) begin
                    w_mem_en_next    = 1'b1;
                    w_mem_we_next    = 1'b1;
                    w_mem_addr_next  = '0;
                    w_mem_wdata_next = '0;
                end else if (r_mem_addr == LAST_ADDR) begin
                    w_state_next    = S_IDLE;
                    w_rst_done_next = 1'b1;
                end else begin
                    w_mem_en_next   = 1'b1;
                    w_mem_we_next   = 1'b1;
                    w_mem_addr_next = r_mem_addr + ADDR_W'(1);
                end
            end
`endif
            S_IDLE: begin
                if (r_rst_done && w_found) begin
                    w_state_next     = S_ISSUE;
                    w_grant_id_next  = w_pick;
                    w_rd_next        = w_rd_pad[w_pick];
                    w_mem_en_next    = 1'b1;
                    w_mem_we_next    = ~w_rd_pad[w_pick];
                    w_mem_addr_next  = w_addr_arr[w_pick];
                    w_mem_wdata_next = w_data_arr[w_pick];
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_rd) begin
                    w_dataout_next = bus.mem_rdata;
                end
                for (int c = 0; c < NUM_CLIENTS; c++) begin
                    w_ack_next[c] = (r_grant_id == 3'(c));
                end
                w_ptr_next   = r_grant_id;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = RESET_STATE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= RESET_STATE;
            r_rst_done  <= 1'b0;
            r_ack       <= '0;
            r_dataout   <= '0;
            r_grant_id  <= '0;
            r_ptr       <= LAST_CLIENT;
            r_rd        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rst_done  <= w_rst_done_next;
            r_ack       <= w_ack_next;
            r_dataout   <= w_dataout_next;
            r_grant_id  <= w_grant_id_next;
            r_ptr       <= w_ptr_next;
            r_rd        <= w_rd_next;
            r_mem_en    <= w_mem_en_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    assign bus.rst_done  = r_rst_done;
    assign bus.ack       = r_ack;
    assign bus.dataout   = r_dataout;
    assign bus.grant_id  = r_grant_id;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_ram_rr_scheduler.sv
// Bench for ram_rr_scheduler: directed scenarios plus a random phase, all
// checked against a transaction-level model (round-robin choice by modulo
// arithmetic, fixed 3-edge latency, scoreboard memory). Honours RAM_CLEAR_EN.
`timescale 1ns/1ps
module tb_ram_rr_scheduler;
    localparam int NC    = 4;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_rr_scheduler_if #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_rr_scheduler #(.NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // RAM macro: registered read, one access per enabled cycle.
    logic [DW-1:0] ram [DEPTH];
    logic          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int a = 0; a < DEPTH; a++) begin
`ifdef RAM_CLEAR_EN
                ram[a] <= 8'h80 | DW'(a * 7 + 3);
`else
                ram[a] <= '0;
`endif
            end
            ram_ready <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    int            edge_n = 0;
    int            m_ptr, m_g, m_gid, m_issue_edge, m_done_edge, m_free_edge;
    logic          inflight;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_dout, last_rd;
    logic [NC-1:0] m_ack_vec;
    logic [DW-1:0] ref_mem [DEPTH];
    int            grant_log[$];
    int            ack_edge_log[$];

    // Client-side stimulus state
    logic [NC-1:0] drv_req = '0, pending = '0, sticky = '0;
    logic          c_rd   [NC];
    logic [AW-1:0] c_addr [NC];
    logic [DW-1:0] c_data [NC];
    bit            random_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.req = drv_req;
        for (int i = 0; i < NC; i++) begin
            bus.rd_not_write[i]      = c_rd[i];
            bus.addr[i*AW +: AW]     = c_addr[i];
            bus.datain[i*DW +: DW]   = c_data[i];
        end
    endtask

    task automatic post(input int c, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_rd[c] = rd; c_addr[c] = a; c_data[c] = d;
        drv_req[c] = 1'b1; pending[c] = 1'b1;
        apply();
    endtask

    task automatic chk_reset_vals();
        chk("rst_rst_done",  32'(bus.rst_done),  32'd0);
        chk("rst_ack",       32'(bus.ack),       32'd0);
        chk("rst_dataout",   32'(bus.dataout),   32'd0);
        chk("rst_grant_id",  32'(bus.grant_id),  32'd0);
        chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    endtask

    // Assert reset now (no edge needed), hold two edges, release, follow start-up.
    task automatic do_reset();
        rst = 1'b1;
        drv_req = '0; pending = '0; sticky = '0;
        apply();
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
`ifdef RAM_CLEAR_EN
        for (int k = 0; k < DEPTH; k++) begin
            @(posedge clk); #1;
            chk("clr_en",       32'(bus.mem_en),    32'd1);
            chk("clr_we",       32'(bus.mem_we),    32'd1);
            chk("clr_addr",     32'(bus.mem_addr),  32'(k));
            chk("clr_wdata",    32'(bus.mem_wdata), 32'd0);
            chk("clr_rst_done", 32'(bus.rst_done),  32'd0);
        end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
`endif
        @(posedge clk); #1;
        chk("start_rst_done", 32'(bus.rst_done), 32'd1);
        chk("start_mem_en",   32'(bus.mem_en),   32'd0);
        m_ptr = NC - 1; m_gid = 0; m_dout = '0; m_ack_vec = '0;
        inflight = 1'b0; m_free_edge = 0;
    endtask

    // One clock: model decides at the edge, outputs checked 1ns later, clients react.
    task automatic cycle();
        logic [NC-1:0] eff, exp_ack;
        logic          got, exp_en;
        int            sel, c;
        @(posedge clk);
        edge_n++;
        if (!inflight && edge_n >= m_free_edge) begin
            eff = drv_req & ~m_ack_vec;
            got = 1'b0; sel = 0;
            for (int k = 1; k <= NC; k++) begin
                c = (m_ptr + k) % NC;
                if (!got && eff[c]) begin got = 1'b1; sel = c; end
            end
            if (got) begin
                inflight = 1'b1; m_g = sel; m_gid = sel; m_ptr = sel;
                m_rd = c_rd[sel]; m_addr = c_addr[sel]; m_data = c_data[sel];
                m_issue_edge = edge_n; m_done_edge = edge_n + 2; m_free_edge = edge_n + 3;
                grant_log.push_back(sel);
            end
        end
        #1;
        exp_ack = '0;
        exp_en  = inflight && (m_issue_edge == edge_n);
        if (inflight && m_done_edge == edge_n) begin
            exp_ack = NC'(1) << m_g;
            if (m_rd) begin m_dout = ref_mem[m_addr]; last_rd = m_dout; end
            else      ref_mem[m_addr] = m_data;
            inflight = 1'b0;
            ack_edge_log.push_back(edge_n);
        end
        chk("ack",      32'(bus.ack),      32'(exp_ack));
        chk("mem_en",   32'(bus.mem_en),   32'(exp_en));
        chk("mem_we",   32'(bus.mem_we),   32'(exp_en & ~m_rd));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        chk("dataout",  32'(bus.dataout),  32'(m_dout));
        chk("rst_done", 32'(bus.rst_done), 32'd1);
        if (exp_en) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            if (!m_rd) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_data));
            if (random_mode && $urandom_range(5) == 0) drv_req[m_g] = 1'b0;
        end
        m_ack_vec = exp_ack;
        for (int i = 0; i < NC; i++) begin
            if (exp_ack[i]) begin
                pending[i] = 1'b0; drv_req[i] = 1'b0;
                if (sticky[i]) post(i, 1'b1, AW'($urandom_range(15)), '0);
            end else if (random_mode && !pending[i] && $urandom_range(2) == 0) begin
                post(i, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom_range(255)));
            end
        end
        apply();
    endtask

    task automatic drain();
        int k = 0;
        while ((pending != '0 || inflight) && k < 200) begin
            cycle();
            k++;
        end
        chk("drain_timeout", 32'(pending != '0 || inflight), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin c_rd[i] = 1'b1; c_addr[i] = '0; c_data[i] = '0; end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        last_rd = '0;
        apply();
        #2;
        do_reset();

        // All four clients request together right after start-up.
        grant_log.delete(); ack_edge_log.delete();
        post(0, 1'b0, 4'h4, 8'h11);
        post(1, 1'b1, 4'h4, 8'h00);
        post(2, 1'b0, 4'h7, 8'h22);
        post(3, 1'b1, 4'h7, 8'h00);
        drain();
        chk("t3_n_grants", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk("t3_order", 32'(grant_log[k]), 32'(k));
        for (int k = 1; k < 4; k++) chk("t3_ack_spacing", 32'(ack_edge_log[k] - ack_edge_log[k-1]), 32'd3);
        chk("t3_rd_after_wr", 32'(last_rd), 32'h22);

        // Read of an untouched address returns zero.
        post(0, 1'b1, 4'h5, 8'h00);
        drain();
        chk("t1_read_zero", 32'(last_rd), 32'h00);

        // Client 2 write then read back.
        post(2, 1'b0, 4'hA, 8'hA5);
        drain();
        post(2, 1'b1, 4'hA, 8'h00);
        drain();
        chk("t2_readback", 32'(last_rd), 32'hA5);

        // Simultaneous write (client 1) and read (client 2) of one address.
        grant_log.delete();
        post(1, 1'b0, 4'h9, 8'hAF);
        post(2, 1'b1, 4'h9, 8'h00);
        drain();
        chk("t5_first",  32'(grant_log[0]), 32'd1);
        chk("t5_second", 32'(grant_log[1]), 32'd2);
        chk("t5_data",   32'(last_rd),      32'hAF);

        // Clients 0 and 3 both keep requesting: strict alternation.
        grant_log.delete();
        sticky[0] = 1'b1; sticky[3] = 1'b1;
        post(0, 1'b1, 4'h1, 8'h00);
        post(3, 1'b1, 4'h2, 8'h00);
        repeat (18) cycle();
        sticky = '0;
        drain();
        chk("t4_count", 32'(grant_log.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++) chk("t4_alternate", 32'(grant_log[k]), ((k % 2) == 0) ? 32'd3 : 32'd0);

        // Random traffic, including occasional REQ drop after grant.
        random_mode = 1'b1;
        repeat (400) cycle();
        random_mode = 1'b0;
        drain();

        // Reset while a client-0 write is in its ISSUE cycle.
        post(0, 1'b0, 4'hC, 8'h3C);
        begin
            int k = 0;
            do begin
                cycle();
                k++;
            end while (!(inflight && m_issue_edge == edge_n) && k < 20);
            chk("t6_grant_seen", 32'(inflight && m_issue_edge == edge_n), 32'd1);
        end
        #1;
        do_reset();
        cycle();
        chk("t6_no_ack", 32'(bus.ack), 32'd0);
        post(1, 1'b0, 4'hC, 8'h77);
        drain();
        post(3, 1'b1, 4'hC, 8'h00);
        drain();
        chk("t6_after_reset", 32'(last_rd), 32'h77);
        post(0, 1'b1, 4'h5, 8'h00);
        drain();
        chk("t6_read5", 32'(last_rd), 32'(ref_mem[5]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
